// File: rtl/snow64_pipe_stage_if_id_queued.sv
// IF/ID stage with a prefetch queue that feeds an external combinational decoder.
// Optional perf counters are enabled by defining SNOW64_IF_ID_PERF_COUNTERS_EN.
module snow64_pipe_stage_if_id_queued #(
    parameter int FETCH_QUEUE_DEPTH = 4,
    parameter int ADDR_WIDTH        = 64,
    parameter int INSTR_WIDTH       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   out_icache_req_valid,
    output logic [ADDR_WIDTH-1:0]  out_icache_req_addr,
    input  logic                   in_icache_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] in_icache_rsp_instr,
    output logic [INSTR_WIDTH-1:0] out_head_instr,
    input  logic [1:0]             in_dec_group,
    input  logic                   in_dec_nop,
    input  logic                   in_ex_stall,
    input  logic [ADDR_WIDTH-1:0]  in_ex_computed_pc,
    input  logic                   in_wb_stall,
    output logic                   out_ex_valid,
    output logic [INSTR_WIDTH-1:0] out_ex_instr,
    output logic [ADDR_WIDTH-1:0]  out_ex_pc,
    output logic [31:0]            out_perf_issued,
    output logic [31:0]            out_perf_bubbles
);

    localparam int PTR_W = $clog2(FETCH_QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(INSTR_WIDTH / 8);
    localparam logic [CNT_W-1:0]      DEPTH = CNT_W'(FETCH_QUEUE_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_LDST0    = 2'd2,
        ST_LDST1    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ex_valid_q, ex_valid_d;
    logic [INSTR_WIDTH-1:0] ex_instr_q, ex_instr_d;
    logic [ADDR_WIDTH-1:0]  ex_pc_q, ex_pc_d;

    logic [ADDR_WIDTH-1:0]  q_pc_q    [FETCH_QUEUE_DEPTH];
    logic [INSTR_WIDTH-1:0] q_instr_q [FETCH_QUEUE_DEPTH];

    logic                   push, pop, flush, head_valid;
    logic [ADDR_WIDTH-1:0]  head_pc;
    logic [INSTR_WIDTH-1:0] head_instr;

    assign head_valid = (count_q != '0);
    assign head_pc    = q_pc_q[rd_ptr_q];
    assign head_instr = q_instr_q[rd_ptr_q];
    assign out_head_instr = head_instr;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign out_icache_req_valid = (state_q == ST_REDIRECT) || (count_q < DEPTH);
    assign out_icache_req_addr  = (state_q == ST_REDIRECT) ? in_ex_computed_pc : fetch_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ex_valid_d = ex_valid_q;
        ex_instr_d = ex_instr_q;
        ex_pc_d    = ex_pc_q;
        pop        = 1'b0;
        flush      = 1'b0;
        push       = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (!in_ex_stall) begin
                    if (!head_valid || in_dec_nop) begin
                        ex_valid_d = 1'b0;
                        ex_instr_d = '0;
                        pop        = head_valid;
                    end else begin
                        ex_valid_d = 1'b1;
                        ex_instr_d = head_instr;
                        ex_pc_d    = head_pc;
                        case (in_dec_group)
                            2'd1: begin
                                ex_pc_d = head_pc + STEP;
                                flush   = 1'b1;
                                state_d = ST_REDIRECT;
                            end
                            2'd2, 2'd3: begin
                                pop     = 1'b1;
                                state_d = ST_LDST0;
                            end
                            default: pop = 1'b1;
                        endcase
                    end
                end
            end
            ST_REDIRECT: begin
                ex_valid_d = 1'b0;
                ex_instr_d = '0;
                fetch_pc_d = in_ex_computed_pc;
                state_d    = ST_RUN;
            end
            ST_LDST0: begin
                ex_valid_d = 1'b0;
                ex_instr_d = '0;
                state_d    = ST_LDST1;
            end
            ST_LDST1: begin
                ex_valid_d = 1'b0;
                ex_instr_d = '0;
                if (!in_wb_stall) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        // The redirect-cycle response belongs to the new target and is dropped.
        push = (state_q != ST_REDIRECT) && out_icache_req_valid && in_icache_rsp_valid && !flush;
        if (push) begin
            fetch_pc_d = fetch_pc_q + STEP;
            wr_ptr_d   = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ex_valid_q <= 1'b0;
            ex_instr_q <= '0;
            ex_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ex_valid_q <= ex_valid_d;
            ex_instr_q <= ex_instr_d;
            ex_pc_q    <= ex_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc_q[wr_ptr_q]    <= fetch_pc_q;
            q_instr_q[wr_ptr_q] <= in_icache_rsp_instr;
        end
    end

    assign out_ex_valid = ex_valid_q;
    assign out_ex_instr = ex_instr_q;
    assign out_ex_pc    = ex_pc_q;

`ifdef SNOW64_IF_ID_PERF_COUNTERS_EN
    logic [31:0] perf_issued_q, perf_bubbles_q;
    logic        perf_issue, perf_bubble;

    // Bubbles are only charged when EX was ready to accept an instruction.
    assign perf_issue  = (state_q == ST_RUN) && !in_ex_stall && head_valid && !in_dec_nop;
    assign perf_bubble = !in_ex_stall && ((state_q != ST_RUN) || !head_valid || in_dec_nop);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_q  <= '0;
            perf_bubbles_q <= '0;
        end else begin
            if (perf_issue)  perf_issued_q  <= perf_issued_q + 32'd1;
            if (perf_bubble) perf_bubbles_q <= perf_bubbles_q + 32'd1;
        end
    end

    assign out_perf_issued  = perf_issued_q;
    assign out_perf_bubbles = perf_bubbles_q;
`else
    assign out_perf_issued  = '0;
    assign out_perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_snow64_pipe_stage_if_id_queued.sv
// Directed bench: the bench supplies the icache and the decoder, checking issue order and timing.
module tb_snow64_pipe_stage_if_id_queued;

    logic        clk;
    logic        rst;
    logic        out_icache_req_valid;
    logic [63:0] out_icache_req_addr;
    logic        in_icache_rsp_valid;
    logic [31:0] in_icache_rsp_instr;
    logic [31:0] out_head_instr;
    logic [1:0]  in_dec_group;
    logic        in_dec_nop;
    logic        in_ex_stall;
    logic [63:0] in_ex_computed_pc;
    logic        in_wb_stall;
    logic        out_ex_valid;
    logic [31:0] out_ex_instr;
    logic [63:0] out_ex_pc;
    logic [31:0] out_perf_issued;
    logic [31:0] out_perf_bubbles;

    // prog entry = {nop, group} for word address addr[9:2]
    logic [2:0] prog [256];
    int n_cmp;
    int n_err;

`ifdef SNOW64_IF_ID_PERF_COUNTERS_EN
    localparam logic [31:0] EXP_ISSUED  = 32'd5;
    localparam logic [31:0] EXP_BUBBLES = 32'd3;
`else
    localparam logic [31:0] EXP_ISSUED  = 32'd0;
    localparam logic [31:0] EXP_BUBBLES = 32'd0;
`endif

    snow64_pipe_stage_if_id_queued #(
        .FETCH_QUEUE_DEPTH(4),
        .ADDR_WIDTH(64),
        .INSTR_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .out_icache_req_valid(out_icache_req_valid),
        .out_icache_req_addr(out_icache_req_addr),
        .in_icache_rsp_valid(in_icache_rsp_valid),
        .in_icache_rsp_instr(in_icache_rsp_instr),
        .out_head_instr(out_head_instr),
        .in_dec_group(in_dec_group),
        .in_dec_nop(in_dec_nop),
        .in_ex_stall(in_ex_stall),
        .in_ex_computed_pc(in_ex_computed_pc),
        .in_wb_stall(in_wb_stall),
        .out_ex_valid(out_ex_valid),
        .out_ex_instr(out_ex_instr),
        .out_ex_pc(out_ex_pc),
        .out_perf_issued(out_perf_issued),
        .out_perf_bubbles(out_perf_bubbles)
    );

    assign in_icache_rsp_instr = {8'hC0, out_icache_req_addr[15:0], 5'b0, prog[out_icache_req_addr[9:2]]};
    assign in_dec_group = out_head_instr[1:0];
    assign in_dec_nop   = out_head_instr[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_ex_stall = 1'b0;
        in_wb_stall = 1'b0;
        in_icache_rsp_valid = 1'b1;
        for (int i = 0; i < 256; i++) prog[i] = 3'b000;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        in_ex_computed_pc = 64'h100;

        // Reset state and back-to-back ALU issue
        do_reset();
        chk("rst_valid", {63'd0, out_ex_valid}, 64'd0);
        chk("rst_instr", {32'd0, out_ex_instr}, 64'd0);
        chk("rst_pc", out_ex_pc, 64'd0);
        chk("rst_req_addr", out_icache_req_addr, 64'd0);
        chk("rst_req_valid", {63'd0, out_icache_req_valid}, 64'd1);
        chk("rst_perf_iss", {32'd0, out_perf_issued}, 64'd0);
        step();
        chk("alu_first_bubble", {63'd0, out_ex_valid}, 64'd0);
        step();
        chk("alu_valid0", {63'd0, out_ex_valid}, 64'd1);
        chk("alu_pc0", out_ex_pc, 64'h0);
        chk("alu_instr0", {32'd0, out_ex_instr}, 64'hC0000000);
        step();
        chk("alu_pc4", out_ex_pc, 64'h4);
        step();
        chk("alu_pc8", out_ex_pc, 64'h8);

        // EX stall: queue fills, fetch stops, outputs hold
        in_ex_stall = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("stall_req_valid", {63'd0, out_icache_req_valid}, 64'd0);
        chk("stall_hold_valid", {63'd0, out_ex_valid}, 64'd1);
        chk("stall_hold_pc", out_ex_pc, 64'h8);
        chk("stall_hold_instr", {32'd0, out_ex_instr}, 64'hC0000800);
        in_ex_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_resume_pc", out_ex_pc, 64'hC + 64'(4 * i));
            chk("stall_resume_valid", {63'd0, out_ex_valid}, 64'd1);
        end

        // Control flow at 0x10 redirecting to 0x100
        do_reset();
        prog[4] = 3'b001;
        for (int i = 0; i < 6; i++) step();
        chk("br_valid", {63'd0, out_ex_valid}, 64'd1);
        chk("br_pc_plus_step", out_ex_pc, 64'h14);
        chk("br_instr", {32'd0, out_ex_instr}, 64'hC0001001);
        chk("redir_req_addr", out_icache_req_addr, 64'h100);
        chk("redir_req_valid", {63'd0, out_icache_req_valid}, 64'd1);
        step();
        chk("redir_bubble", {63'd0, out_ex_valid}, 64'd0);
        chk("redir_bubble_instr", {32'd0, out_ex_instr}, 64'd0);
        chk("redir_bubble_pc_held", out_ex_pc, 64'h14);
        chk("redir_fetch_addr", out_icache_req_addr, 64'h100);
        step();
        chk("redir_empty_bubble", {63'd0, out_ex_valid}, 64'd0);
        step();
        chk("redir_tgt0_valid", {63'd0, out_ex_valid}, 64'd1);
        chk("redir_tgt0_pc", out_ex_pc, 64'h100);
        step();
        chk("redir_tgt1_pc", out_ex_pc, 64'h104);

        // Load at 0x20 with WB stall for three LDST1 cycles
        do_reset();
        prog[8] = 3'b010;
        in_wb_stall = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("ld_valid", {63'd0, out_ex_valid}, 64'd1);
        chk("ld_pc", out_ex_pc, 64'h20);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ld_wait_bubble", {63'd0, out_ex_valid}, 64'd0);
            chk("ld_wait_pc_held", out_ex_pc, 64'h20);
        end
        chk("ld_queue_full", {63'd0, out_icache_req_valid}, 64'd0);
        in_wb_stall = 1'b0;
        step();
        chk("ld_exit_bubble", {63'd0, out_ex_valid}, 64'd0);
        step();
        chk("ld_next_valid", {63'd0, out_ex_valid}, 64'd1);
        chk("ld_next_pc", out_ex_pc, 64'h24);
        step();
        chk("ld_next2_pc", out_ex_pc, 64'h28);

        // Reset while in REDIRECT
        do_reset();
        prog[4] = 3'b001;
        for (int i = 0; i < 6; i++) step();
        chk("pre_rst_redir_addr", out_icache_req_addr, 64'h100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("redir_rst_valid", {63'd0, out_ex_valid}, 64'd0);
        chk("redir_rst_pc", out_ex_pc, 64'd0);
        chk("redir_rst_fetch_pc", out_icache_req_addr, 64'd0);
        step();
        chk("redir_rst_empty", {63'd0, out_ex_valid}, 64'd0);
        step();
        chk("redir_rst_issue_pc", out_ex_pc, 64'd0);
        chk("redir_rst_issue_valid", {63'd0, out_ex_valid}, 64'd1);

        // Five ALU and two NOPs for the counters
        do_reset();
        prog[2] = 3'b100;
        prog[4] = 3'b100;
        for (int i = 0; i < 4; i++) step();
        chk("nop_bubble", {63'd0, out_ex_valid}, 64'd0);
        chk("nop_bubble_pc_held", out_ex_pc, 64'h4);
        for (int i = 0; i < 4; i++) step();
        chk("perf_last_pc", out_ex_pc, 64'h18);
        in_ex_stall = 1'b1;
        chk("perf_issued", {32'd0, out_perf_issued}, {32'd0, EXP_ISSUED});
        chk("perf_bubbles", {32'd0, out_perf_bubbles}, {32'd0, EXP_BUBBLES});
        step();
        chk("perf_issued_stall", {32'd0, out_perf_issued}, {32'd0, EXP_ISSUED});
        chk("perf_bubbles_stall", {32'd0, out_perf_bubbles}, {32'd0, EXP_BUBBLES});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
